mem_store_unit: RTL and testbench

//  Store-side counterpart of the ALU load formatter. It accepts MEM_WRITE ops
//  (opselect 3'b100) from the execute stage and forms byte-lane write data and

---
 rtl/mem_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_unit.sv
// Store formatter and write buffer between the execute stage and data memory.
// Latency: a store taken at edge T drives mem_req from the cycle right after T when the buffer was empty.
// Backpressure: stall is high while the buffer is full. Memory backpressure comes from mem_ack, and the request holds until it is acked.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   enable, aluopselect     op valid and op class (a store is 3'b100)
//   aluoperation            000 SB, 001 SH, 010 SW; other codes are illegal
//   aluin1, aluin2          byte address and store data
//   stall                   buffer full; a store presented now is not taken
//   store_err               one-cycle pulse when a misaligned or illegal store is dropped
//   mem_req/addr/wdata/be   write request to memory and its payload
//   mem_ack                 memory accepts the current request this cycle
//   store_done              one-cycle pulse in the cycle after each accepted request
module mem_store_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [2:0]   aluopselect,
  input  logic [2:0]   aluoperation,
  input  logic [N-1:0] aluin1,
  input  logic [N-1:0] aluin2,
  output logic         stall,
  output logic         store_err,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ack,
  output logic         store_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic          stall_q, stall_d;
  logic          store_err_q, store_err_d;
  logic          store_done_q, store_done_d;
  logic [N-1:0]  addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic [N-1:0]  addr_mem  [DEPTH];
  logic [N-1:0]  wdata_mem [DEPTH];
  logic [3:0]    be_mem    [DEPTH];

  logic          is_store, legal, aligned, push, bad, pop, load;
  logic [N-1:0]  fmt_addr, fmt_wdata;
  logic [3:0]    fmt_be;

  // Decode, check, and lane-format the op on the input side.
  always_comb begin
    legal     = 1'b0;
    aligned   = 1'b0;
    fmt_be    = 4'b0000;
    fmt_wdata = '0;
    case (aluoperation)
      3'b000: begin
        legal     = 1'b1;
        aligned   = 1'b1;
        fmt_be    = 4'b0001 << aluin1[1:0];
        fmt_wdata = {4{aluin2[7:0]}};
      end
      3'b001: begin
        legal     = 1'b1;
        aligned   = ~aluin1[0];
        fmt_be    = aluin1[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{aluin2[15:0]}};
      end
      3'b010: begin
        legal     = 1'b1;
        aligned   = (aluin1[1:0] == 2'b00);
        fmt_be    = 4'b1111;
        fmt_wdata = aluin2;
      end
      default: begin
        legal     = 1'b0;
        aligned   = 1'b0;
      end
    endcase
    fmt_addr = {aluin1[N-1:2], 2'b00};
    // The stall flag is registered. A pop in the same cycle does not open a slot for this store.
    is_store = enable && (aluopselect == 3'b100) && !stall_q;
    push     = is_store && legal && aligned;
    bad      = is_store && !(legal && aligned);
  end

  // Next-state logic for the FSM, the FIFO bookkeeping, and the presented request.
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    pop          = (state_q == S_REQ) && mem_ack;
    count_d      = count_q + CW'(push) - CW'(pop);
    remain       = count_q - CW'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    stall_d      = (count_d == FULL);
    store_err_d  = bad;
    store_done_d = pop;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;

    case (state_q)
      S_IDLE: begin
        if (count_d != '0) begin
          state_d = S_REQ;
          load    = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (count_d == '0) state_d = S_IDLE;
          else               load    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The new head is either a buffered entry or the store being written this cycle.
    // The second case applies when nothing else remains after the pop.
    if (load) begin
      if (remain == '0) begin
        addr_d  = fmt_addr;
        wdata_d = fmt_wdata;
        be_d    = fmt_be;
      end else begin
        addr_d  = addr_mem[rd_ptr_d];
        wdata_d = wdata_mem[rd_ptr_d];
        be_d    = be_mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stall_q      <= 1'b0;
      store_err_q  <= 1'b0;
      store_done_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stall_q      <= stall_d;
      store_err_q  <= store_err_d;
      store_done_q <= store_done_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // Buffer storage. It has no reset because count and the pointers decide which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= fmt_addr;
      wdata_mem[wr_ptr_q] <= fmt_wdata;
      be_mem[wr_ptr_q]    <= fmt_be;
    end
  end

  assign stall      = stall_q;
  assign store_err  = store_err_q;
  assign store_done = store_done_q;
  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;

endmodule

// File: tb/tb_mem_store_unit.sv
module tb_mem_store_unit;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  aluopselect, aluoperation;
  logic [31:0] aluin1, aluin2;
  logic        stall, store_err, mem_req, store_done, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  mem_store_unit #(.N(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .aluopselect(aluopselect), .aluoperation(aluoperation),
    .aluin1(aluin1), .aluin2(aluin2),
    .stall(stall), .store_err(store_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .store_done(store_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  // Reference model: a queue of pending stores plus the values the outputs should show.
  ent_t        q[$];
  logic        m_req, m_stall, m_err, m_done;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] issued[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Advance one clock: predict from the pre-edge inputs, then compare all outputs after the edge.
  task automatic step();
    ent_t e;
    bit take, ok, ack_eff;
    logic n_req, n_stall, n_err, n_done;
    logic [31:0] n_addr, n_wdata;
    logic [3:0] n_be;
    int lane;
    n_addr = m_addr; n_wdata = m_wdata; n_be = m_be;
    lane = int'(aluin1 % 4);
    ack_eff = m_req && mem_ack;
    if (mem_req && mem_ack) issued.push_back(mem_addr);
    take = enable && (aluopselect == 3'd4) && !m_stall;
    ok = (aluoperation == 3'd0) ||
         (aluoperation == 3'd1 && (lane % 2) == 0) ||
         (aluoperation == 3'd2 && lane == 0);
    if (reset) begin
      q.delete();
      n_req = 0; n_stall = 0; n_err = 0; n_done = 0;
      n_addr = 0; n_wdata = 0; n_be = 0;
    end else begin
      if (ack_eff) void'(q.pop_front());
      if (take && ok) begin
        e.a = aluin1 - 32'(lane);
        case (aluoperation)
          3'd0: begin e.be = 4'(1 << lane); e.d = {24'd0, aluin2[7:0]} * 32'h01010101; end
          3'd1: begin e.be = (lane == 2) ? 4'hC : 4'h3; e.d = {16'd0, aluin2[15:0]} * 32'h00010001; end
          default: begin e.be = 4'hF; e.d = aluin2; end
        endcase
        q.push_back(e);
      end
      n_err   = take && !ok;
      n_done  = ack_eff;
      n_req   = (q.size() > 0);
      n_stall = (q.size() == DEPTH);
      if (n_req && (!m_req || ack_eff)) begin
        n_addr = q[0].a; n_wdata = q[0].d; n_be = q[0].be;
      end
    end
    @(posedge clock);
    #1;
    m_req = n_req; m_stall = n_stall; m_err = n_err; m_done = n_done;
    m_addr = n_addr; m_wdata = n_wdata; m_be = n_be;
    chk("mem_req", mem_req, m_req);
    chk("stall", stall, m_stall);
    chk("store_err", store_err, m_err);
    chk("store_done", store_done, m_done);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_be", mem_be, m_be);
  endtask

  task automatic present(input logic [2:0] sel, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d);
    enable = 1; aluopselect = sel; aluoperation = op; aluin1 = a; aluin2 = d;
  endtask

  initial begin
    int n;
    reset = 1; enable = 0; aluopselect = 0; aluoperation = 0;
    aluin1 = 0; aluin2 = 0; mem_ack = 0;
    m_req = 0; m_stall = 0; m_err = 0; m_done = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    step(); step();
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 0; step();

    // SW, ack arrives after two waiting cycles
    present(3'd4, 3'd2, 32'h100, 32'hDEADBEEF); step();
    enable = 0;
    chk("sw_req_a", mem_req, 1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_be", mem_be, 4'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    step(); chk("sw_req_b", mem_req, 1);
    step(); chk("sw_req_c", mem_req, 1); chk("sw_hold_addr", mem_addr, 32'h100);
    mem_ack = 1; step();
    chk("sw_req_off", mem_req, 0); chk("sw_done", store_done, 1);
    mem_ack = 0; step(); chk("sw_done_once", store_done, 0);

    // SB with immediate ack
    mem_ack = 1;
    present(3'd4, 3'd0, 32'h203, 32'h000000A5); step();
    enable = 0;
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_be", mem_be, 4'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    step(); chk("sb_done", store_done, 1);
    mem_ack = 0;

    // SH upper half, then a misaligned SH
    present(3'd4, 3'd1, 32'h102, 32'h00001234); step();
    enable = 0;
    chk("sh_be", mem_be, 4'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    mem_ack = 1; step(); mem_ack = 0;
    present(3'd4, 3'd1, 32'h101, 32'h00005678); step();
    enable = 0;
    chk("sh_mis_err", store_err, 1);
    chk("sh_mis_noreq", mem_req, 0);
    step(); chk("err_pulse_end", store_err, 0);

    // Fill the buffer, retry while stalled, then drain
    present(3'd4, 3'd2, 32'h300, 32'h11111111); step();
    chk("fill1_stall", stall, 0);
    present(3'd4, 3'd2, 32'h304, 32'h22222222); step();
    chk("fill2_stall", stall, 1);
    present(3'd4, 3'd2, 32'h308, 32'h33333333); step();
    chk("retry_stall_a", stall, 1);
    step(); chk("retry_stall_b", stall, 1);
    issued.delete();
    mem_ack = 1;
    n = 0;
    while (enable && n < 8) begin
      if (!m_stall) begin step(); enable = 0; end
      else step();
      n++;
    end
    n = 0;
    while (mem_req && n < 8) begin step(); n++; end
    chk("drain_cycles", n, 1);
    chk("issued_cnt", issued.size(), 3);
    if (issued.size() == 3) begin
      chk("issued0", issued[0], 32'h300);
      chk("issued1", issued[1], 32'h304);
      chk("issued2", issued[2], 32'h308);
    end
    mem_ack = 0;

    // Illegal op versus a non-store op class
    present(3'd4, 3'd7, 32'h0, 32'h0); step();
    chk("illegal_err", store_err, 1);
    present(3'd1, 3'd2, 32'h0, 32'h0); step();
    enable = 0;
    chk("nonstore_err", store_err, 0);
    chk("nonstore_req", mem_req, 0);

    // Reset with two stores queued and a request pending
    present(3'd4, 3'd2, 32'h400, 32'hAAAA5555); step();
    present(3'd4, 3'd2, 32'h404, 32'h5555AAAA); step();
    enable = 0;
    chk("pre_rst_req", mem_req, 1);
    reset = 1; step();
    chk("midrst_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    reset = 0; mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_done", store_done, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      enable       = ($urandom_range(0, 9) < 7);
      aluopselect  = ($urandom_range(0, 9) < 8) ? 3'd4 : 3'($urandom_range(0, 7));
      aluoperation = ($urandom_range(0, 19) < 17) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      aluin1       = $urandom;
      aluin2       = $urandom;
      mem_ack      = $urandom_range(0, 1) == 1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
